// File: rtl/led_scan_arbiter.sv
// led_scan_arbiter
//   Shares the single dmem port between the CPU (always wins) and an
//   LED-matrix refresh engine. The engine fetches 16-word frames into a back
//   buffer during idle memory cycles and swaps them into the front buffer at
//   frame-period boundaries. The front buffer is scanned out as 16 rows of
//   32 active-low columns, stepping through NUM_FRAMES animation frames.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   cpu_a/cpu_wd/cpu_we   : CPU byte address, write data, write enable
//   cpu_cs                : CPU chip select (active-low)
//   cpu_rd                : CPU read data (mem_rd when selected, else high-Z)
//   mem_a/mem_wd/mem_we   : dmem address, write data, write enable
//   mem_cs                : dmem chip select (active-low)
//   mem_rd                : dmem combinational read data
//   row_idx, col_data     : current row and active-low column drive
//   row_strobe            : one-cycle pulse on the first cycle of each row
//   frame_idx             : animation frame currently displayed
//
// Configuration macro
//   SCAN_BLANK_EN : when defined, the first BLANK_CYCLES clocks of every row
//                   drive col_data all ones (LEDs off) to suppress ghosting.
module led_scan_arbiter #(
    parameter int ROW_CYCLES   = 1000,
    parameter int FRAME_HOLD   = 50,
    parameter int NUM_FRAMES   = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_wd,
    input  logic        cpu_we,
    input  logic        cpu_cs,
    output logic [31:0] cpu_rd,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        mem_cs,
    input  logic [31:0] mem_rd,
    output logic [3:0]  row_idx,
    output logic [31:0] col_data,
    output logic        row_strobe,
    output logic [3:0]  frame_idx
);

    localparam int RCW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int RFW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [RCW-1:0] ROW_LAST   = RCW'(ROW_CYCLES - 1);
    localparam logic [RFW-1:0] HOLD_LAST  = RFW'(FRAME_HOLD - 1);
    localparam logic [3:0]     FRAME_LAST = 4'(NUM_FRAMES - 1);

    // Elaboration-time guard against unusable parameter sets.
    if (ROW_CYCLES < 2 || FRAME_HOLD < 1 || NUM_FRAMES < 1 || NUM_FRAMES > 16 ||
        BLANK_CYCLES < 0 || BLANK_CYCLES >= ROW_CYCLES) begin : g_param_check
        $error("led_scan_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        SHOW_FETCH = 2'd1,
        SHOW_READY = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      word_reg;          // next back-buffer word to fetch
    logic            back_valid_reg;
    logic [3:0]      fetch_frame_reg;
    logic [3:0]      frame_reg;
    logic [3:0]      row_reg;
    logic [RCW-1:0]  row_cnt_reg;       // clock within the current row
    logic [RFW-1:0]  refresh_reg;       // full refreshes of the current frame
    logic            strobe_reg;
    logic [31:0]     back_reg  [16];
    logic [31:0]     front_reg [16];

    logic            engine_cycle;
    logic            fetch_done;
    logic            row_end;
    logic            period_end;
    logic            load_front;
    logic            swap;
    logic [31:0]     scan_cols;
    logic [31:0]     row_word [4];

    // ------------------------------------------------------------------
    // Port arbitration (purely combinational, CPU never stalls)
    // ------------------------------------------------------------------
    assign engine_cycle = !back_valid_reg && cpu_cs;
    assign fetch_done   = engine_cycle && (word_reg == 4'd15);

    always_comb begin
        mem_a  = cpu_a;
        mem_wd = cpu_wd;
        mem_we = cpu_we;
        mem_cs = 1'b0;
        if (cpu_cs) begin
            mem_we = 1'b0;
            if (engine_cycle) begin
                // frame f, word i lives at word address 16f + i
                mem_a  = {22'd0, fetch_frame_reg, word_reg, 2'b00};
                mem_cs = 1'b0;
            end else begin
                mem_cs = 1'b1;
            end
        end
    end

    assign cpu_rd = cpu_cs ? 32'bz : mem_rd;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    assign row_end    = (state_reg != FILL) && (row_cnt_reg == ROW_LAST);
    assign period_end = row_end && (row_reg == 4'd15) && (refresh_reg == HOLD_LAST);

    always_comb begin
        state_next = state_reg;
        load_front = 1'b0;
        swap       = 1'b0;
        case (state_reg)
            FILL: begin
                if (fetch_done) begin
                    state_next = SHOW_FETCH;
                    load_front = 1'b1;
                end
            end
            SHOW_FETCH: begin
                // A period end here means the fetch was starved: keep the
                // current frame for another period.
                if (fetch_done) begin
                    state_next = SHOW_READY;
                end
            end
            SHOW_READY: begin
                if (period_end) begin
                    state_next = SHOW_FETCH;
                    load_front = 1'b1;
                    swap       = 1'b1;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Fetch, frame bookkeeping and scan counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg        <= 4'd0;
            back_valid_reg  <= 1'b0;
            fetch_frame_reg <= 4'd0;
            frame_reg       <= 4'd0;
            row_reg         <= 4'd0;
            row_cnt_reg     <= '0;
            refresh_reg     <= '0;
            strobe_reg      <= 1'b0;
        end else begin
            strobe_reg <= 1'b0;

            if (engine_cycle) begin
                word_reg <= word_reg + 4'd1;
            end

            // The initial fill goes straight to the front buffer, so only a
            // fetch completed while showing leaves the back buffer valid.
            if (fetch_done && state_reg == SHOW_FETCH) begin
                back_valid_reg <= 1'b1;
            end else if (swap) begin
                back_valid_reg <= 1'b0;
            end

            if (load_front) begin
                fetch_frame_reg <= (fetch_frame_reg == FRAME_LAST) ? 4'd0
                                                                    : fetch_frame_reg + 4'd1;
            end
            if (swap) begin
                frame_reg <= fetch_frame_reg;
            end

            if (state_reg == FILL) begin
                if (load_front) begin
                    row_reg     <= 4'd0;
                    row_cnt_reg <= '0;
                    refresh_reg <= '0;
                    strobe_reg  <= 1'b1;
                end
            end else if (row_end) begin
                row_cnt_reg <= '0;
                row_reg     <= row_reg + 4'd1;
                strobe_reg  <= 1'b1;
                if (row_reg == 4'd15) begin
                    refresh_reg <= (refresh_reg == HOLD_LAST) ? '0 : refresh_reg + 1'b1;
                end
            end else begin
                row_cnt_reg <= row_cnt_reg + 1'b1;
            end
        end
    end

    // Back buffer: written one word per engine cycle, read in parallel on
    // a front-buffer load, so it is kept in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (engine_cycle) begin
            back_reg[word_reg] <= mem_rd;
        end
    end

    // On the fill-completion edge word 15 is still on mem_rd, not yet in
    // the back buffer, so it is forwarded straight into the front buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < 16; w++) begin
                front_reg[w] <= '1;
            end
        end else if (load_front) begin
            for (int w = 0; w < 15; w++) begin
                front_reg[w] <= back_reg[w];
            end
            front_reg[15] <= fetch_done ? mem_rd : back_reg[15];
        end
    end

    // ------------------------------------------------------------------
    // Scan mapping: row r takes byte r/4 of word 4b + r%4 for block b.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        assign row_word[gi]         = front_reg[{2'(gi), row_reg[1:0]}];
        assign scan_cols[8*gi +: 8] = row_word[gi][{row_reg[3:2], 3'b000} +: 8];
    end

`ifdef SCAN_BLANK_EN
    assign col_data = (row_cnt_reg < RCW'(BLANK_CYCLES)) ? 32'hFFFF_FFFF : scan_cols;
`else
    assign col_data = scan_cols;
`endif

    assign row_idx    = row_reg;
    assign row_strobe = strobe_reg;
    assign frame_idx  = frame_reg;

endmodule

// File: tb/tb_led_scan_arbiter.sv
module tb_led_scan_arbiter;

    localparam int ROW_CYCLES   = 4;
    localparam int FRAME_HOLD   = 2;
    localparam int NUM_FRAMES   = 2;
    localparam int BLANK_CYCLES = 2;
    localparam int PERIOD       = 16 * ROW_CYCLES * FRAME_HOLD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_a = '0;
    logic [31:0] cpu_wd = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_cs = 1'b1;
    wire  [31:0] cpu_rd;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we, mem_cs;
    logic [3:0]  row_idx, frame_idx;
    logic [31:0] col_data;
    logic        row_strobe;

    logic [31:0] ram     [64];   // dmem as seen by the DUT
    logic [31:0] ram_exp [64];   // memory contents the model expects

    int vectors = 0;
    int miscompares = 0;

    led_scan_arbiter #(
        .ROW_CYCLES  (ROW_CYCLES),
        .FRAME_HOLD  (FRAME_HOLD),
        .NUM_FRAMES  (NUM_FRAMES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_a     (cpu_a),
        .cpu_wd    (cpu_wd),
        .cpu_we    (cpu_we),
        .cpu_cs    (cpu_cs),
        .cpu_rd    (cpu_rd),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_cs    (mem_cs),
        .mem_rd    (mem_rd),
        .row_idx   (row_idx),
        .col_data  (col_data),
        .row_strobe(row_strobe),
        .frame_idx (frame_idx)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_a[7:2]];
    always @(posedge clk) begin
        if (!mem_cs && mem_we) ram[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        $display("vec %-16s got %h expected %h", nm, act, exp);
        chk(nm, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: scan position is a running clock count since the
    // first row-0 strobe; rows, strobes and periods follow by division.
    // ------------------------------------------------------------------
    bit          m_live = 1'b0;
    bit          m_scan, m_full, m_boundary;
    int          m_pos, m_n, m_ffr, m_disp;
    logic [31:0] m_front [16];
    logic [31:0] m_back  [16];

    always @(posedge clk) begin
        if (reset) begin
            m_scan = 1'b0; m_full = 1'b0; m_pos = 0; m_n = 0; m_ffr = 0; m_disp = 0;
            for (int w = 0; w < 16; w++) m_front[w] = '1;
            m_live = 1'b1;
        end else if (m_live) begin
            m_boundary = 1'b0;
            if (m_scan) begin
                m_pos++;
                m_boundary = (m_pos % PERIOD == 0);
            end
            if (m_boundary && m_full) begin
                m_front = m_back;
                m_disp  = m_ffr;
                m_ffr   = (m_ffr + 1) % NUM_FRAMES;
                m_full  = 1'b0;
            end else if (!m_full && cpu_cs) begin
                m_back[m_n] = ram_exp[m_ffr * 16 + m_n];
                m_n++;
                if (m_n == 16) begin
                    m_n = 0;
                    if (!m_scan) begin
                        m_front = m_back;
                        m_scan  = 1'b1;
                        m_pos   = 0;
                        m_ffr   = (m_ffr + 1) % NUM_FRAMES;
                    end else begin
                        m_full = 1'b1;
                    end
                end
            end
        end
        if (!cpu_cs && cpu_we) ram_exp[cpu_a[7:2]] = cpu_wd;
    end

    // Per-cycle compare against the model, away from the active edge.
    int          c_row, c_ph;
    logic [31:0] c_col, c_w;
    logic        c_eng;

    always @(negedge clk) begin
        if (m_live) begin
            c_row = m_scan ? (m_pos / ROW_CYCLES) % 16 : 0;
            c_ph  = m_pos % ROW_CYCLES;
            c_col = '0;
            for (int b = 0; b < 4; b++) begin
                c_w = m_front[4 * b + c_row % 4] >> (8 * (c_row / 4));
                c_col[8 * b +: 8] = c_w[7:0];
            end
`ifdef SCAN_BLANK_EN
            if (c_ph < BLANK_CYCLES) c_col = 32'hFFFF_FFFF;
`endif
            chk("row_idx", {28'd0, row_idx}, 32'(c_row));
            chk("col_data", col_data, c_col);
            chk("row_strobe", {31'd0, row_strobe}, {31'd0, m_scan && c_ph == 0});
            chk("frame_idx", {28'd0, frame_idx}, 32'(m_disp));
            c_eng = !m_full && cpu_cs;
            chk("mem_cs", {31'd0, mem_cs}, {31'd0, cpu_cs && !c_eng});
            chk("mem_we", {31'd0, mem_we}, {31'd0, !cpu_cs && cpu_we});
            if (!cpu_cs) begin
                chk("mem_a_cpu", mem_a, cpu_a);
                chk("mem_wd_cpu", mem_wd, cpu_wd);
                chk("cpu_rd", cpu_rd, ram_exp[cpu_a[7:2]]);
            end else if (c_eng) begin
                chk("mem_a_fetch", mem_a, 32'((m_ffr * 16 + m_n) * 4));
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    logic [31:0] blank_or_row1;
    logic [31:0] blank_or_row0;

    initial begin
        for (int w = 0; w < 64; w++) begin
            if (w < 16)      ram[w] = 32'(32'h1111_1111 * w);
            else if (w < 32) ram[w] = 32'h0F0F_0F0F ^ 32'(32'h1111_1111 * (w - 16));
            else             ram[w] = '0;
        end
        ram[1]  = ~32'h0000_0000;
        ram[5]  = ~32'h423C_7E42;
        ram[9]  = ~32'h0;
        ram[13] = ~32'h0;
        for (int w = 0; w < 64; w++) ram_exp[w] = ram[w];

`ifdef SCAN_BLANK_EN
        blank_or_row0 = 32'hFFFF_FFFF;
        blank_or_row1 = 32'hFFFF_FFFF;
`else
        blank_or_row0 = 32'hCC88_4400;
        blank_or_row1 = 32'hFFFF_BDFF;
`endif

        // ---- fill and row mapping ----
        reset = 1'b1; cpu_cs = 1'b1;
        step(2);
        dchk("rst_col", col_data, 32'hFFFF_FFFF);
        dchk("rst_frame", {28'd0, frame_idx}, 32'd0);
        reset = 1'b0;
        step(15);
        dchk("fill_e15_strobe", {31'd0, row_strobe}, 32'd0);
        step(1);
        dchk("fill_e16_strobe", {31'd0, row_strobe}, 32'd1);
        dchk("fill_e16_row", {28'd0, row_idx}, 32'd0);
        dchk("fill_e16_col", col_data, blank_or_row0);
        step(2);
        dchk("row0_col", col_data, 32'hCC88_4400);
        step(2);
        dchk("row1_idx", {28'd0, row_idx}, 32'd1);
        dchk("row1_strobe", {31'd0, row_strobe}, 32'd1);
        dchk("row1_col_start", col_data, blank_or_row1);
        step(2);
        dchk("row1_col", col_data, 32'hFFFF_BDFF);

        // ---- frame advance and wrap ----
        step(121);
        dchk("e143_frame", {28'd0, frame_idx}, 32'd0);
        step(1);
        dchk("e144_frame", {28'd0, frame_idx}, 32'd1);
        step(2);
        dchk("f1_row0_col", col_data, 32'hC387_4B0F);
        step(126);
        dchk("e272_frame_wrap", {28'd0, frame_idx}, 32'd0);
        step(128);
        dchk("e400_frame", {28'd0, frame_idx}, 32'd1);

        // ---- reset during row 7 of frame 1 ----
        step(29);
        dchk("pre_rst_row", {28'd0, row_idx}, 32'd7);
        reset = 1'b1;
        step(1);
        dchk("mrst_col", col_data, 32'hFFFF_FFFF);
        dchk("mrst_frame", {28'd0, frame_idx}, 32'd0);
        dchk("mrst_mem_a", mem_a, 32'd0);
        dchk("mrst_mem_cs", {31'd0, mem_cs}, 32'd0);
        reset = 1'b0;

        // ---- CPU priority during fill (edges 5..7 belong to the CPU) ----
        step(4);
        cpu_cs = 1'b0; cpu_we = 1'b1; cpu_a = 32'd0;      cpu_wd = 32'h1234_5678;
        step(1);
        cpu_a = 32'd200; cpu_wd = 32'hDEAD_BEEF;
        step(1);
        cpu_a = 32'd204; cpu_wd = 32'hCAFE_F00D;
        step(1);
        cpu_cs = 1'b1; cpu_we = 1'b0;
        step(11);
        dchk("late_e18_strobe", {31'd0, row_strobe}, 32'd0);
        step(1);
        dchk("late_e19_strobe", {31'd0, row_strobe}, 32'd1);
        dchk("ram_w0", ram[0], 32'h1234_5678);
        dchk("ram_w50", ram[50], 32'hDEAD_BEEF);
        dchk("ram_w51", ram[51], 32'hCAFE_F00D);

        // ---- starvation: CPU holds the port from here ----
        cpu_cs = 1'b0; cpu_we = 1'b0; cpu_a = 32'd200;
        step(2);
        dchk("cpu_read", cpu_rd, 32'hDEAD_BEEF);
        dchk("stale_row0_col", col_data, 32'hCC88_4400);
        step(125);
        dchk("starve_e146", {28'd0, frame_idx}, 32'd0);
        step(1);
        dchk("starve_e147_frame", {28'd0, frame_idx}, 32'd0);
        dchk("starve_e147_row", {28'd0, row_idx}, 32'd0);
        step(3);
        cpu_cs = 1'b1;
        step(124);
        dchk("release_e274", {28'd0, frame_idx}, 32'd0);
        step(1);
        dchk("release_e275", {28'd0, frame_idx}, 32'd1);
        step(2);
        dchk("release_f1_col", col_data, 32'hC387_4B0F);
        step(126);
        dchk("refetch_e403", {28'd0, frame_idx}, 32'd0);
        step(2);
        dchk("refetch_row0", col_data, 32'hCC88_4478);

        for (int w = 0; w < 64; w++) chk("ram_contents", ram[w], ram_exp[w]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
